// File: rtl/door_pkg.sv
// -----------------------------------------------------------------------------
// door_pkg
// Shared definitions for the keypad door-lock front end:
//   - door_state_e : controller state encoding (NORMAL / LOCKOUT / ALARM)
//   - KEY1..KEY4   : bit index of each keypad button in btn_raw / btn_fwd
//   - DEF_*        : default policy values used as parameter defaults
// -----------------------------------------------------------------------------
package door_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_LOCKOUT = 2'd1,
        ST_ALARM   = 2'd2
    } door_state_e;

    localparam int KEY1 = 0;
    localparam int KEY2 = 1;
    localparam int KEY3 = 2;
    localparam int KEY4 = 3;

    localparam int DEF_MAX_FAIL    = 3;
    localparam int DEF_LOCK_TICKS  = 30;
    localparam int DEF_MAX_STRIKES = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
// Brings the four asynchronous keypad buttons into the clk domain with a
// 2-flop synchroniser, then detects 0->1 transitions against a third flop.
// The press vector is registered, so a raw edge captured at edge N shows up
// on press during the cycle after edge N+2.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset, clears every flop
//   btn_raw  in   [3:0] raw button levels (asynchronous)
//   press    out  [3:0] one-cycle rising-edge pulses, one bit per button
// -----------------------------------------------------------------------------
module btn_sync_edge (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] press
);

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] sync3_q, sync3_d;
    logic [3:0] press_q, press_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        // Only a 0->1 transition produces a pulse; a held button stays quiet.
        press_d = sync2_q & ~sync3_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            press_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/door_access_ctrl.sv
// -----------------------------------------------------------------------------
// door_access_ctrl
// Keypad door-lock front end. Forwards single key presses to the code checker,
// counts consecutive failed entries, enforces a timed lockout after MAX_FAIL
// failures and latches a sticky alarm after MAX_STRIKES lockouts. Only
// admin_clear (or reset) leaves the alarm.
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   tick           in   one-cycle time-base strobe for the lockout timer
//   btn_raw        in   [3:0] raw asynchronous buttons, bit0=key1 .. bit3=key4
//   admin_clear    in   synchronous clear of counters, lockout and alarm
//   code_ok        in   checker pulse: full code accepted
//   code_fail      in   checker pulse: wrong key
//   btn_fwd        out  [3:0] one-hot press pulse to the checker
//   checker_rst    out  one-cycle pulse forcing the checker to idle
//   locked         out  high in LOCKOUT and ALARM
//   alarm          out  high in ALARM
//   fail_count     out  [FAIL_W-1:0] consecutive failures
//   lock_remaining out  [LOCK_W-1:0] ticks left in lockout, 0 otherwise
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module door_access_ctrl
    import door_pkg::*;
#(
    parameter int MAX_FAIL    = DEF_MAX_FAIL,
    parameter int LOCK_TICKS  = DEF_LOCK_TICKS,
    parameter int MAX_STRIKES = DEF_MAX_STRIKES,
    parameter int FAIL_W      = 2,
    parameter int LOCK_W      = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic [3:0]        btn_raw,
    input  logic              admin_clear,
    input  logic              code_ok,
    input  logic              code_fail,
    output logic [3:0]        btn_fwd,
    output logic              checker_rst,
    output logic              locked,
    output logic              alarm,
    output logic [FAIL_W-1:0] fail_count,
    output logic [LOCK_W-1:0] lock_remaining
);

    localparam int FC_W     = FAIL_W + 1;
    localparam int STRIKE_W = $clog2(MAX_STRIKES + 1);

    logic [3:0] press;

    door_state_e       state_q, state_d;
    logic [FAIL_W-1:0] fail_count_q, fail_count_d;
    logic [STRIKE_W-1:0] strikes_q, strikes_d;
    logic [LOCK_W-1:0] lock_remaining_q, lock_remaining_d;
    logic [3:0]        btn_fwd_q, btn_fwd_d;
    logic              checker_rst_q, checker_rst_d;
    logic              locked_q, locked_d;
    logic              alarm_q, alarm_d;

    logic              press_multi;
    logic              press_single;
    logic              failure;
    logic [FC_W-1:0]   fail_inc;
    logic [STRIKE_W-1:0] strikes_inc;

    btn_sync_edge u_btn_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_raw),
        .press   (press)
    );

    always_comb begin
        state_d          = state_q;
        fail_count_d     = fail_count_q;
        strikes_d        = strikes_q;
        lock_remaining_d = lock_remaining_q;
        btn_fwd_d        = '0;
        checker_rst_d    = 1'b0;

        // Clearing the lowest set bit leaves something only if >=2 bits are set.
        press_multi  = ((press & (press - 4'd1)) != 4'd0);
        press_single = (press != 4'd0) && !press_multi;
        failure      = code_fail || press_multi;
        fail_inc     = {1'b0, fail_count_q} + FC_W'(1);
        strikes_inc  = (strikes_q >= STRIKE_W'(MAX_STRIKES)) ? strikes_q
                                                              : strikes_q + STRIKE_W'(1);

        if (admin_clear) begin
            state_d          = ST_NORMAL;
            fail_count_d     = '0;
            strikes_d        = '0;
            lock_remaining_d = '0;
            checker_rst_d    = 1'b1;
        end else begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (press_multi) begin
                        checker_rst_d = 1'b1;
                    end
                    if (failure) begin
                        // A failure outranks a coincident code_ok.
                        if (fail_inc >= FC_W'(MAX_FAIL)) begin
                            fail_count_d  = '0;
                            strikes_d     = strikes_inc;
                            checker_rst_d = 1'b1;
                            if (strikes_inc >= STRIKE_W'(MAX_STRIKES)) begin
                                state_d          = ST_ALARM;
                                lock_remaining_d = '0;
                            end else begin
                                state_d          = ST_LOCKOUT;
                                lock_remaining_d = LOCK_W'(LOCK_TICKS);
                            end
                        end else begin
                            fail_count_d = fail_inc[FAIL_W-1:0];
                            if (press_single) begin
                                btn_fwd_d = press;
                            end
                        end
                    end else begin
                        if (press_single) begin
                            btn_fwd_d = press;
                        end
                        if (code_ok) begin
                            fail_count_d = '0;
                            strikes_d    = '0;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (tick) begin
                        if (lock_remaining_q <= LOCK_W'(1)) begin
                            state_d          = ST_NORMAL;
                            lock_remaining_d = '0;
                        end else begin
                            lock_remaining_d = lock_remaining_q - LOCK_W'(1);
                        end
                    end
                end
                ST_ALARM: begin
                    lock_remaining_d = '0;
                end
                default: begin
                    state_d          = ST_NORMAL;
                    fail_count_d     = '0;
                    strikes_d        = '0;
                    lock_remaining_d = '0;
                end
            endcase
        end

        locked_d = (state_d != ST_NORMAL);
        alarm_d  = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_NORMAL;
            fail_count_q     <= '0;
            strikes_q        <= '0;
            lock_remaining_q <= '0;
            btn_fwd_q        <= '0;
            checker_rst_q    <= 1'b0;
            locked_q         <= 1'b0;
            alarm_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            fail_count_q     <= fail_count_d;
            strikes_q        <= strikes_d;
            lock_remaining_q <= lock_remaining_d;
            btn_fwd_q        <= btn_fwd_d;
            checker_rst_q    <= checker_rst_d;
            locked_q         <= locked_d;
            alarm_q          <= alarm_d;
        end
    end

    assign btn_fwd        = btn_fwd_q;
    assign checker_rst    = checker_rst_q;
    assign locked         = locked_q;
    assign alarm          = alarm_q;
    assign fail_count     = fail_count_q;
    assign lock_remaining = lock_remaining_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_door_access_ctrl
// Scoreboard bench for door_access_ctrl. The stimulus process pushes the
// expected output snapshot for every observable event; the monitor pops one
// entry whenever the DUT shows a pulse (btn_fwd / checker_rst) or a change of
// its level outputs, and compares the whole snapshot (plus the cycle when an
// exact latency is expected).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_door_access_ctrl;
    import door_pkg::*;

    typedef struct packed {
        logic [3:0] fwd;
        logic       crst;
        logic       lk;
        logic       al;
        logic [1:0] fc;
        logic [5:0] lr;
    } snap_t;

    typedef struct {
        string tag;
        int    cyc;
        snap_t s;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [3:0] btn_raw;
    logic       admin_clear;
    logic       code_ok;
    logic       code_fail;
    logic [3:0] btn_fwd;
    logic       checker_rst;
    logic       locked;
    logic       alarm;
    logic [1:0] fail_count;
    logic [5:0] lock_remaining;

    door_access_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tick           (tick),
        .btn_raw        (btn_raw),
        .admin_clear    (admin_clear),
        .code_ok        (code_ok),
        .code_fail      (code_fail),
        .btn_fwd        (btn_fwd),
        .checker_rst    (checker_rst),
        .locked         (locked),
        .alarm          (alarm),
        .fail_count     (fail_count),
        .lock_remaining (lock_remaining)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    bit   done   = 1'b0;

    task automatic expect_ev(input string tag, input int c, input logic [3:0] f,
                             input logic r, input logic l, input logic a,
                             input logic [1:0] fc, input logic [5:0] lr);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.s   = {f, r, l, a, fc, lr};
        exp_q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        snap_t s;
        snap_t prev;
        exp_t  e;
        bit    first;
        bit    evt;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk or negedge reset_n);
            #1;
            if (done) break;
            if (mon_en) begin
                s   = {btn_fwd, checker_rst, locked, alarm, fail_count, lock_remaining};
                evt = first || (s.fwd != 4'd0) || s.crst ||
                      ({s.lk, s.al, s.fc, s.lr} != {prev.lk, prev.al, prev.fc, prev.lr});
                prev  = s;
                first = 1'b0;
                if (evt) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event @cyc %0d: got fwd=%b rst=%b lk=%b al=%b fc=%0d lr=%0d, want no event",
                                 cyc, s.fwd, s.crst, s.lk, s.al, s.fc, s.lr);
                    end else begin
                        e = exp_q.pop_front();
                        if (s != e.s || (e.cyc >= 0 && e.cyc != cyc)) begin
                            errors++;
                            $display("FAIL %s @cyc %0d: got fwd=%b rst=%b lk=%b al=%b fc=%0d lr=%0d, want fwd=%b rst=%b lk=%b al=%b fc=%0d lr=%0d cyc=%0d",
                                     e.tag, cyc, s.fwd, s.crst, s.lk, s.al, s.fc, s.lr,
                                     e.s.fwd, e.s.crst, e.s.lk, e.s.al, e.s.fc, e.s.lr, e.cyc);
                        end
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d outstanding, want 0 (next '%s')",
                     exp_q.size(), exp_q[0].tag);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fail(input logic with_tick);
        code_fail = 1'b1;
        tick      = with_tick;
        step(1);
        code_fail = 1'b0;
        tick      = 1'b0;
        step(1);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(1);
    endtask

    task automatic run_lockout_out();
        for (int i = 29; i >= 1; i--) begin
            expect_ev("lock_tick", -1, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 6'(i));
            do_tick();
        end
        expect_ev("unlock", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        do_tick();
        step(2);
    endtask

    initial begin
        reset_n     = 1'b0;
        tick        = 1'b0;
        btn_raw     = 4'd0;
        admin_clear = 1'b0;
        code_ok     = 1'b0;
        code_fail   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        expect_ev("reset", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        mon_en = 1'b1;
        step(2);

        // held key3: one pulse, edge N = cyc+1, visible after edge N+3
        btn_raw[KEY3] = 1'b1;
        expect_ev("hold_key3", cyc + 4, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        step(20);
        btn_raw = 4'd0;
        step(6);

        // three failures -> lockout; tick on the load cycle is ignored
        expect_ev("fail1", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 6'd0);
        pulse_fail(1'b0);
        expect_ev("fail2", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 6'd0);
        pulse_fail(1'b0);
        expect_ev("lockout", -1, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0, 6'd30);
        pulse_fail(1'b1);
        btn_raw[KEY4] = 1'b1;
        step(6);
        btn_raw = 4'd0;
        step(4);
        pulse_fail(1'b0);
        run_lockout_out();

        // second lockout without code_ok -> alarm, sticky through 100 ticks
        expect_ev("fail1_b", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 6'd0);
        pulse_fail(1'b0);
        expect_ev("fail2_b", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 6'd0);
        pulse_fail(1'b0);
        expect_ev("alarm", -1, 4'd0, 1'b1, 1'b1, 1'b1, 2'd0, 6'd0);
        pulse_fail(1'b0);
        tick          = 1'b1;
        btn_raw[KEY2] = 1'b1;
        step(10);
        btn_raw   = 4'd0;
        code_fail = 1'b1;
        step(1);
        code_fail = 1'b0;
        step(89);
        tick = 1'b0;
        step(2);
        expect_ev("admin_clear", -1, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
        admin_clear = 1'b1;
        step(1);
        admin_clear = 1'b0;
        step(3);

        // two keys rising together: no forward, one failure, checker reset
        btn_raw = 4'b0011;
        expect_ev("multi_press", cyc + 4, 4'd0, 1'b1, 1'b0, 1'b0, 2'd1, 6'd0);
        step(8);
        btn_raw = 4'd0;
        step(6);

        // code_ok with code_fail: failure wins
        expect_ev("ok_and_fail", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 6'd0);
        code_ok   = 1'b1;
        code_fail = 1'b1;
        step(1);
        code_ok   = 1'b0;
        code_fail = 1'b0;
        step(2);
        expect_ev("ok_clear", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        code_ok = 1'b1;
        step(1);
        code_ok = 1'b0;
        step(2);

        // lockout, then code_ok clears strikes so the next trip is a lockout
        expect_ev("fail1_c", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 6'd0);
        pulse_fail(1'b0);
        expect_ev("fail2_c", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 6'd0);
        pulse_fail(1'b0);
        expect_ev("lockout_c", -1, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0, 6'd30);
        pulse_fail(1'b0);
        run_lockout_out();
        code_ok = 1'b1;
        step(1);
        code_ok = 1'b0;
        step(2);
        expect_ev("fail1_d", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 6'd0);
        pulse_fail(1'b0);
        expect_ev("fail2_d", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 6'd0);
        pulse_fail(1'b0);
        expect_ev("lockout_d", -1, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0, 6'd30);
        pulse_fail(1'b0);
        for (int i = 29; i >= 12; i--) begin
            expect_ev("lock_tick_d", -1, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 6'(i));
            do_tick();
        end
        pulse_fail(1'b0);

        // asynchronous reset mid-lockout, between clock edges
        @(posedge clk);
        #2;
        expect_ev("async_reset", -1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(2);
        btn_raw[KEY1] = 1'b1;
        expect_ev("after_reset", cyc + 4, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
        step(8);
        btn_raw = 4'd0;
        step(6);

        done = 1'b1;
    end

endmodule

// File: doc/door_access_ctrl.md
Name: door_access_ctrl

Overview:
Front-end controller for the keypad door lock. Synchronises and edge-detects the four raw keypad buttons and forwards single-cycle press pulses to the code-sequence checker. Counts failed entries and imposes a timed lockout after repeated failures. Escalates to a sticky alarm after repeated lockouts, cleared only by an admin input.

Parameters:
MAX_FAIL, 3, consecutive failed entries that trigger a lockout (>=1)
LOCK_TICKS, 30, lockout duration in tick strobes (>=1)
MAX_STRIKES, 2, lockouts since last clear that trigger ALARM (>=1)
FAIL_W, 2, width of fail_count; must hold MAX_FAIL
LOCK_W, 6, width of lock_remaining; must hold LOCK_TICKS

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
tick  in  1  one-cycle time-base strobe (1 Hz nominal)
btn_raw  in  4  raw buttons, asynchronous; bit0=key1 .. bit3=key4
admin_clear  in  1  synchronous clear of counters, lockout and alarm
code_ok  in  1  one-cycle pulse from checker: full code accepted
code_fail  in  1  one-cycle pulse from checker: wrong key
btn_fwd  out  4  one-cycle one-hot press pulse to checker
checker_rst  out  1  one-cycle pulse forcing checker to idle
locked  out  1  high in LOCKOUT and ALARM
alarm  out  1  high in ALARM
fail_count  out  FAIL_W  consecutive failures since last success/clear
lock_remaining  out  LOCK_W  ticks left in lockout, 0 otherwise

Behaviour:
- Reset (reset_n low, async): state NORMAL. All outputs 0. Synchronisers, strike counter and timers 0.
- Input path: 2-flop synchroniser per bit, then a third flop for edge detect. press = sync & ~sync_d. Only 0->1 transitions count; holding a button gives one press.
- Latency: raw rising edge captured at clock edge N -> btn_fwd high for the single cycle after edge N+3. All outputs are registered.
- States: NORMAL, LOCKOUT, ALARM.
- NORMAL:
  - press with exactly one bit set -> forwarded on btn_fwd.
  - press with >=2 bits set -> nothing forwarded. Counts as one failure and pulses checker_rst.
  - code_fail or multi-press -> fail_count+1.
  - code_ok -> fail_count=0 and strikes=0.
  - code_ok and a failure in the same cycle -> the failure wins.
  - When the incremented fail_count would reach MAX_FAIL, all in the next cycle:
    - fail_count=0, strikes+1, checker_rst pulse.
    - If strikes+1 == MAX_STRIKES -> ALARM.
    - Otherwise -> LOCKOUT with lock_remaining=LOCK_TICKS.
- LOCKOUT:
  - All presses dropped; btn_fwd stays 0; code_ok/code_fail ignored.
  - Each tick decrements lock_remaining.
  - Tick that moves 1->0 -> NORMAL in the same update.
  - A tick coincident with the load cycle is ignored; the load wins.
- ALARM: presses dropped, locked=1, alarm=1, lock_remaining=0. Exits only via admin_clear or reset.
- admin_clear (any state, highest priority after reset):
  - Next cycle: NORMAL, fail_count=0, strikes=0, lock_remaining=0.
  - checker_rst pulse one cycle; any press in that cycle dropped.
- Strike counter saturates at MAX_STRIKES. fail_count never exceeds MAX_FAIL-1 when observed.
- Reset mid-lockout or mid-alarm: immediate return to NORMAL, all state cleared.

Decomposition:
- Shared package door_pkg:
  - state encoding typedef (NORMAL/LOCKOUT/ALARM)
  - key index constants KEY1..KEY4
  - default MAX_FAIL/LOCK_TICKS/MAX_STRIKES
- One sub-module, btn_sync_edge: 4-bit 2-flop synchroniser plus rising-edge detect. Outputs press[3:0]; reset_n clears it.
- Counters and FSM stay in door_access_ctrl.

Test Plan:
- Raw btn bit2 rises and is held 20 cycles -> exactly one btn_fwd=4'b0100 pulse, 4 cycles after the capturing edge; no further pulses.
- Three code_fail pulses in NORMAL -> fail_count 1,2, then 0 with locked=1, lock_remaining=30, one checker_rst pulse. 30 ticks later -> locked=0. Presses during lockout -> btn_fwd stays 0.
- Second lockout sequence (MAX_STRIKES=2) without intervening code_ok -> alarm=1, locked=1. 100 ticks pass -> still ALARM. admin_clear -> next cycle alarm=0, locked=0, fail_count=0, checker_rst pulse.
- btn_raw=4'b0011 rising simultaneously -> btn_fwd stays 0, fail_count+1, checker_rst pulse.
- code_ok and code_fail in the same cycle with fail_count=1 -> fail_count=2, no clear.
- reset_n asserted asynchronously mid-LOCKOUT (lock_remaining=12) -> all outputs 0 immediately, without waiting for a clock edge. After release, NORMAL and presses forwarded.
